dma_buffer_reader: RTL and testbench

Read-side engine for the DMA block's dual-port SSRAM staging buffer. Once the buffer holds a block of words, this engine reads them through the asynchronous read port. It cuts the block into bus bursts and presents each word on the system-bus write interface with request/grant and stall handling. It is the drain end of the buffer, opposite the bus-read path that fills it.

---
 rtl/dma_buffer_reader.sv | 195 +++++++++++++++++++
 tb/tb_dma_buffer_reader.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : dma_buffer_reader
// Purpose  : Drain engine for the DMA staging buffer. Reads a block of words
//            through the SSRAM asynchronous read port. Splits the block into
//            bus bursts and presents each word on the system-bus write side
//            with request/grant and stall handling.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset       single clock, synchronous active-high reset
//   start              one-cycle command pulse, honoured only when idle
//   startAddress       first buffer entry of the block
//   wordCount          block length in words, 0..nrOfEntries
//   burstSize          maximum words per bus burst, 1..maxBurstSize
//   busy, done         transfer in progress / one-cycle completion pulse
//   bufferAddress      SSRAM read address (the read pointer itself)
//   bufferData         combinational SSRAM read data for bufferAddress
//   busRequest         bus request, held across the whole transfer
//   busGrant           arbiter grant
//   beginTransaction   one-cycle burst-start pulse, with burstLength
//   burstLength        words in the burst being started
//   writeData          registered data beat, qualified by dataValid
//   busStall           slave back-pressure; the current beat is held
//   endTransaction     one-cycle burst-end pulse
// ============================================================================
module dma_buffer_reader #(
  parameter  int bitwidth     = 32,
  parameter  int nrOfEntries  = 512,
  parameter  int maxBurstSize = 16,
  localparam int c_aw         = $clog2(nrOfEntries),
  localparam int c_bw         = $clog2(maxBurstSize) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [c_aw-1:0]     startAddress,
  input  logic [c_aw:0]       wordCount,
  input  logic [c_bw-1:0]     burstSize,
  output logic                busy,
  output logic                done,
  output logic [c_aw-1:0]     bufferAddress,
  input  logic [bitwidth-1:0] bufferData,
  output logic                busRequest,
  input  logic                busGrant,
  output logic                beginTransaction,
  output logic [c_bw-1:0]     burstLength,
  output logic [bitwidth-1:0] writeData,
  output logic                dataValid,
  input  logic                busStall,
  output logic                endTransaction
);

  // Compare width wide enough for both the remaining count and the burst size
  localparam int c_cw = ((c_aw + 1) > c_bw) ? (c_aw + 1) : c_bw;

  localparam logic [c_aw:0]   c_rem_one  = 1;
  localparam logic [c_bw-1:0] c_beat_one = 1;
  localparam logic [c_aw-1:0] c_ptr_one  = 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_BEGIN   = 3'd2,
    S_DATA    = 3'd3,
    S_END     = 3'd4
  } state_t;

  state_t                r_state;
  logic [c_aw:0]         r_remaining;
  logic [c_bw-1:0]       r_burst_size;
  logic [c_bw-1:0]       r_beats_left;
  logic [c_aw-1:0]       r_read_pointer;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_bus_request;
  logic                  r_begin;
  logic [c_bw-1:0]       r_burst_length;
  logic [bitwidth-1:0]   r_write_data;
  logic                  r_data_valid;
  logic                  r_end;

  logic [c_cw-1:0]       w_rem_ext;
  logic [c_cw-1:0]       w_bs_ext;
  logic [c_bw-1:0]       w_burst_len;
  logic                  w_beat_accepted;
  logic                  w_last_beat;

  assign w_rem_ext = c_cw'(r_remaining);
  assign w_bs_ext  = c_cw'(r_burst_size);

  // When fewer words remain than a full burst, the remaining count fits in
  // the burst-length width, so the narrow slice is lossless on that branch.
  assign w_burst_len = (w_rem_ext < w_bs_ext) ? r_remaining[c_bw-1:0] : r_burst_size;

  assign w_beat_accepted = r_data_valid && !busStall;
  assign w_last_beat     = (r_beats_left == c_beat_one);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_remaining    <= '0;
      r_burst_size   <= '0;
      r_beats_left   <= '0;
      r_read_pointer <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_bus_request  <= 1'b0;
      r_begin        <= 1'b0;
      r_burst_length <= '0;
      r_write_data   <= '0;
      r_data_valid   <= 1'b0;
      r_end          <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_begin <= 1'b0;
      r_end   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (wordCount == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remaining    <= wordCount;
              r_read_pointer <= startAddress;
              r_burst_size   <= burstSize;
              r_busy         <= 1'b1;
              r_bus_request  <= 1'b1;
              r_state        <= S_REQUEST;
            end
          end
        end

        S_REQUEST: begin
          if (busGrant) begin
            r_begin        <= 1'b1;
            r_burst_length <= w_burst_len;
            r_beats_left   <= w_burst_len;
            r_state        <= S_BEGIN;
          end
        end

        S_BEGIN: begin
          // Prefetch the first beat; the pointer then runs one word ahead
          r_write_data   <= bufferData;
          r_read_pointer <= r_read_pointer + c_ptr_one;
          r_data_valid   <= 1'b1;
          r_state        <= S_DATA;
        end

        S_DATA: begin
          if (w_beat_accepted) begin
            r_remaining  <= r_remaining - c_rem_one;
            r_beats_left <= r_beats_left - c_beat_one;
            if (w_last_beat) begin
              r_data_valid <= 1'b0;
              r_end        <= 1'b1;
              r_state      <= S_END;
            end else begin
              r_write_data   <= bufferData;
              r_read_pointer <= r_read_pointer + c_ptr_one;
            end
          end
        end

        S_END: begin
          // Request stays asserted between bursts; a new grant is awaited
          if (r_remaining != '0) begin
            r_state <= S_REQUEST;
          end else begin
            r_busy        <= 1'b0;
            r_bus_request <= 1'b0;
            r_done        <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign bufferAddress    = r_read_pointer;
  assign busRequest       = r_bus_request;
  assign beginTransaction = r_begin;
  assign burstLength      = r_burst_length;
  assign writeData        = r_write_data;
  assign dataValid        = r_data_valid;
  assign endTransaction   = r_end;

endmodule
`default_nettype wire

// File: tb/tb_dma_buffer_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_buffer_reader
// Purpose  : Scoreboard bench for dma_buffer_reader. Transfers are modelled
//            at block level (burst split, wrapped word sequence, latency).
//            A negedge monitor compares everything the DUT presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_buffer_reader;

  localparam int BITWIDTH = 32;
  localparam int ENTRIES  = 512;
  localparam int MAXB     = 16;
  localparam int AW       = 9;
  localparam int BW       = 5;

  logic                clock = 1'b0;
  logic                reset;
  logic                start;
  logic [AW-1:0]       startAddress;
  logic [AW:0]         wordCount;
  logic [BW-1:0]       burstSize;
  logic                busy;
  logic                done;
  logic [AW-1:0]       bufferAddress;
  logic [BITWIDTH-1:0] bufferData;
  logic                busRequest;
  logic                busGrant;
  logic                beginTransaction;
  logic [BW-1:0]       burstLength;
  logic [BITWIDTH-1:0] writeData;
  logic                dataValid;
  logic                busStall;
  logic                endTransaction;

  logic [BITWIDTH-1:0] mem [ENTRIES];
  assign bufferData = mem[bufferAddress];

  dma_buffer_reader #(
    .bitwidth    (BITWIDTH),
    .nrOfEntries (ENTRIES),
    .maxBurstSize(MAXB)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .startAddress    (startAddress),
    .wordCount       (wordCount),
    .burstSize       (burstSize),
    .busy            (busy),
    .done            (done),
    .bufferAddress   (bufferAddress),
    .bufferData      (bufferData),
    .busRequest      (busRequest),
    .busGrant        (busGrant),
    .beginTransaction(beginTransaction),
    .burstLength     (burstLength),
    .writeData       (writeData),
    .dataValid       (dataValid),
    .busStall        (busStall),
    .endTransaction  (endTransaction)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int start_cyc;
    int count;
    int final_addr;
    int lat;
  } xfer_t;

  xfer_t               q_x[$];
  int                  q_len[$];
  logic [BITWIDTH-1:0] q_data[$];

  int checks = 0;
  int errors = 0;

  int grant_prob = 100;
  int stall_mode = 0;
  int stall_prob = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Block-level model: split into min(remaining, burst) chunks, walk the
  // buffer modulo its depth, and total up the ideal cycle count.
  task automatic do_start(input int sa, input int wc, input int bs, input bit det, input int extra);
    xfer_t r;
    int    rem;
    int    ptr;
    int    lat;
    int    n;
    @(posedge clock); #1;
    start        = 1'b1;
    startAddress = AW'(sa);
    wordCount    = (AW+1)'(wc);
    burstSize    = BW'(bs);
    rem = wc;
    ptr = sa;
    lat = 1;
    while (rem > 0) begin
      n = (rem < bs) ? rem : bs;
      q_len.push_back(n);
      for (int k = 0; k < n; k++) begin
        q_data.push_back(mem[ptr]);
        ptr = (ptr + 1) % ENTRIES;
      end
      rem -= n;
      lat += n + 3;
    end
    r.start_cyc  = cyc;
    r.count      = wc;
    r.final_addr = (sa + wc) % ENTRIES;
    r.lat        = det ? (lat + extra) : -1;
    q_x.push_back(r);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (q_x.size() != 0 && t < budget) begin
      @(posedge clock);
      t++;
    end
    if (q_x.size() != 0) begin
      chk(1'b0, "timeout", t, budget);
      q_x.delete();
      q_len.delete();
      q_data.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
    end
    repeat (2) @(posedge clock);
  endtask

  // Arbiter: grant after a random wait, drop it during endTransaction so
  // every burst needs a fresh grant.
  initial begin
    busGrant = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (reset || endTransaction || !busRequest)
        busGrant = 1'b0;
      else if (!busGrant && ($urandom_range(99) < grant_prob))
        busGrant = 1'b1;
    end
  end

  // Slave back-pressure: none, random, or three cycles on the second beat
  initial begin
    int d_beats = 0;
    int s_cnt   = 0;
    bit last_dv = 1'b0;
    bit last_st = 1'b0;
    busStall = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (last_dv && !last_st) d_beats++;
      if (!busy) begin
        d_beats = 0;
        s_cnt   = 0;
      end
      case (stall_mode)
        2: begin
          if (dataValid && d_beats == 1 && s_cnt < 3) begin
            busStall = 1'b1;
            s_cnt++;
          end else begin
            busStall = 1'b0;
          end
        end
        1:       busStall = ($urandom_range(99) < stall_prob);
        default: busStall = 1'b0;
      endcase
      last_dv = dataValid;
      last_st = busStall;
    end
  end

  // Monitor
  bit                  rst_seen     = 1'b0;
  bit                  burst_active = 1'b0;
  bit                  prev_dv      = 1'b0;
  bit                  prev_stall   = 1'b0;
  logic [BITWIDTH-1:0] prev_wd      = '0;
  int                  cur_len      = 0;
  int                  beats        = 0;
  xfer_t               rec;

  always @(negedge clock) begin
    if (reset) begin
      rst_seen     = 1'b1;
      burst_active = 1'b0;
      prev_dv      = 1'b0;
      prev_stall   = 1'b0;
      q_x.delete();
      q_len.delete();
      q_data.delete();
    end else begin
      if (rst_seen) begin
        rst_seen = 1'b0;
        chk({busy, done, busRequest, beginTransaction, dataValid, endTransaction} == 6'b0 &&
            burstLength == '0 && bufferAddress == '0,
            "reset_ctrl_outputs",
            longint'({burstLength, bufferAddress, busy, done, busRequest,
                      beginTransaction, dataValid, endTransaction}), 0);
        chk(writeData == '0, "reset_writeData", writeData, 0);
      end

      chk(busRequest == busy, "busRequest_tracks_busy", busRequest, busy);

      if (q_x.size() > 0 && cyc == q_x[0].start_cyc + 1) begin
        chk(busy == (q_x[0].count > 0), "busy_after_start", busy, q_x[0].count > 0);
      end

      if (beginTransaction) begin
        if (q_len.size() == 0) begin
          chk(1'b0, "unexpected_begin", 1, 0);
        end else begin
          cur_len = q_len.pop_front();
          chk(burstLength == BW'(cur_len), "burstLength", burstLength, cur_len);
        end
        beats        = 0;
        burst_active = 1'b1;
      end

      if (prev_dv && prev_stall) begin
        chk(dataValid && writeData == prev_wd, "stall_hold", writeData, prev_wd);
      end

      if (dataValid && !busStall) begin
        if (q_data.size() == 0) begin
          chk(1'b0, "unexpected_beat", writeData, 0);
        end else begin
          logic [BITWIDTH-1:0] e;
          e = q_data.pop_front();
          chk(writeData == e, "writeData", writeData, e);
        end
        beats++;
      end

      if (endTransaction) begin
        chk(burst_active && beats == cur_len, "end_beat_count", burst_active ? beats : -1, cur_len);
        burst_active = 1'b0;
      end

      if (done) begin
        if (q_x.size() == 0) begin
          chk(1'b0, "unexpected_done", 1, 0);
        end else begin
          rec = q_x.pop_front();
          chk(!busy, "busy_low_at_done", busy, 0);
          chk(q_len.size() == 0 && q_data.size() == 0, "all_drained",
              q_len.size() + q_data.size(), 0);
          if (rec.count > 0)
            chk(int'(bufferAddress) == rec.final_addr, "final_address", bufferAddress, rec.final_addr);
          if (rec.lat >= 0)
            chk(cyc - rec.start_cyc == rec.lat, "start_to_done", cyc - rec.start_cyc, rec.lat);
        end
      end

      prev_dv    = dataValid;
      prev_stall = busStall;
      prev_wd    = writeData;
    end
  end

  initial begin
    int t;
    int wc;
    reset        = 1'b1;
    start        = 1'b0;
    startAddress = '0;
    wordCount    = '0;
    burstSize    = BW'(1);
    for (int i = 0; i < ENTRIES; i++) mem[i] = BITWIDTH'(i + 100);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Single burst, immediate grant
    do_start(0, 4, 4, 1'b1, 0);
    wait_done(200);
    // Three bursts 4,4,2
    do_start(0, 10, 4, 1'b1, 0);
    wait_done(400);
    // Wrap across the top of the buffer
    do_start(ENTRIES - 2, 4, 4, 1'b1, 0);
    wait_done(200);
    // Three stall cycles on the second beat
    stall_mode = 2;
    do_start(0, 4, 4, 1'b1, 3);
    wait_done(200);
    stall_mode = 0;
    // Empty block
    do_start(0, 0, 4, 1'b1, 0);
    wait_done(50);

    // Reset during the second data beat
    do_start(0, 4, 4, 1'b1, 0);
    t = 0;
    while (!dataValid && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (!dataValid) chk(1'b0, "reset_test_no_data", t, 50);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;

    // Clean transfer with a stray start pulse while busy
    do_start(20, 9, 3, 1'b1, 0);
    repeat (3) @(posedge clock);
    #1;
    start        = 1'b1;
    startAddress = AW'(100);
    wordCount    = (AW+1)'(7);
    burstSize    = BW'(2);
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(300);

    // Randomized transfers
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] = $urandom;
      grant_prob = $urandom_range(20, 100);
      stall_mode = 1;
      stall_prob = $urandom_range(0, 50);
      if (k == 0)          wc = ENTRIES;
      else if (k % 7 == 3) wc = 0;
      else                 wc = $urandom_range(1, 40);
      do_start($urandom_range(0, ENTRIES - 1), wc, $urandom_range(1, MAXB), 1'b0, 0);
      wait_done(6000);
    end
    stall_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
